multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath; sequences every instruction through fetch, decode, execute, memory and writeback.
- Consumes opcode/func from the instruction register, the ALU zero flag and a memory-ready handshake.
- Drives all datapath enables and mux selects: PC, IR, register file, ALU source muxes, ALU control, memory and PC-source.
- One instance per core, between the unified memory interface and the register-file/ALU datapath.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready before entering TRAP; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  6  IR[31:26]; must be valid during DECODE.
- func  in  6  IR[5:0]; must be valid during DECODE.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load, already qualified internally with zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  2  write-register select: 0 = rt, 1 = rd, 2 = r31.
- mem_to_reg  out  2  write-data select: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm shifted left 2.
- ext_zero  out  1  zero-extend imm (andi/ori).
- alu_ctrl  out  4  ALU operation code.
- pc_source  out  2  PC source select: 0 = ALU, 1 = ALUOut, 2 = jump target.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse in an instruction's last state.
- trap  out  1  sticky illegal-opcode/timeout flag; cleared only by reset.

Behaviour:
- Moore FSM; outputs decode from the state register plus a latched op-class/alu_ctrl register captured in DECODE.
- Reset (rst_n = 0 at edge):
  - state <= FETCH, trap <= 0, timeout counter <= 0.
  - While rst_n is low, every strobe (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, instr_done) is forced 0.
  - All selects are 0 and alu_ctrl = ADD.
  - Reset mid-instruction abandons it without any write.
- FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 1, alu_ctrl = ADD, pc_source = 0.
  - ir_write and pc_write are asserted only in the cycle mem_ready = 1; that cycle moves to DECODE, otherwise stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_ctrl = ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 -> R_EXEC
  - 0x23 / 0x2B -> MEM_ADDR
  - 0x04 / 0x05 -> BRANCH
  - 0x08 / 0x0C / 0x0D / 0x0A -> I_EXEC
  - 0x02 / 0x03 -> JUMP
  - anything else -> TRAP
- R_EXEC: alu_src_a = 1, alu_src_b = 0. alu_ctrl from func:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
  - Any other func -> TRAP.
  - Next state: R_WB.
- R_WB: reg_dst = 1, mem_to_reg = 0, reg_write = 1, instr_done = 1 -> FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ADD -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read = 1, i_or_d = 1; wait for mem_ready -> MEM_WB.
- MEM_WB: reg_dst = 0, mem_to_reg = 1, reg_write = 1, instr_done -> FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1; hold until mem_ready, then instr_done -> FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, SUB, pc_source = 1.
  - pc_write_cond = zero for beq, ~zero for bne.
  - instr_done -> FETCH.
- I_EXEC: alu_src_a = 1, alu_src_b = 2.
  - addi ADD; andi AND with ext_zero; ori OR with ext_zero; slti SLT.
  - Next state: I_WB.
- I_WB: reg_dst = 0, mem_to_reg = 0, reg_write = 1, instr_done -> FETCH.
- JUMP: pc_source = 2, pc_write = 1, instr_done.
  - jal also sets reg_dst = 2, mem_to_reg = 2, reg_write = 1; PC already holds PC+4.
  - Next state: FETCH.
- TRAP: all strobes 0; trap = 1; stays in TRAP until reset.
- Timeout: counter increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready = 0 and clears on state change.
  - When the count reaches MEM_TIMEOUT (if MEM_TIMEOUT is nonzero) -> TRAP.
  - mem_ready arriving on the same cycle the count expires takes priority: the access completes.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch / jump: 3 cycles
- Each memory wait cycle adds one cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (4-bit encoding)
  - alu_ctrl codes: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111, SLL 1000, SRL 1001
  - opcode/func constants
  - mux select constants
- Sub-module alu_ctrl_decode: combinational func/opcode -> alu_ctrl plus illegal flag; its output is latched in DECODE.

Test Plan:
- add $3,$1,$2 (op 0, func 0x20), mem_ready tied 1:
  - required states FETCH, DECODE, R_EXEC, R_WB.
  - reg_write and reg_dst = 1 in cycle 4; instr_done pulses once.
- lw with mem_ready delayed 3 cycles in MEM_RD:
  - mem_read and i_or_d = 1 held for 4 cycles.
  - reg_write with mem_to_reg = 1 one cycle after mem_ready; total 8 cycles.
- beq with zero = 1, then bne with zero = 1:
  - beq: pc_write_cond = 1, pc_source = 1.
  - bne: pc_write_cond = 0.
  - Both take 3 cycles.
- jal (op 0x03):
  - pc_write = 1, pc_source = 2, reg_write = 1, reg_dst = 2, mem_to_reg = 2 in cycle 3.
- Opcode 0x3F:
  - DECODE -> TRAP; trap = 1 and no strobes for 20 cycles.
  - rst_n low for 1 edge -> FETCH, trap = 0.
- MEM_TIMEOUT = 16 with mem_ready stuck 0 in FETCH:
  - TRAP after 16 wait cycles.
  - Separately, rst_n asserted during MEM_WR: mem_write drops in that cycle and the next state is FETCH.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Brief    : Shared types and constants for the multicycle MIPS control FSM:
//            state encoding, ALU operation codes, opcode/func values and
//            datapath mux select codes.
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

   // Controller states, 4-bit encoding (also exported on the debug port)
   typedef enum logic [3:0] {
      st_fetch    = 4'd0,
      st_decode   = 4'd1,
      st_r_exec   = 4'd2,
      st_r_wb     = 4'd3,
      st_mem_addr = 4'd4,
      st_mem_rd   = 4'd5,
      st_mem_wb   = 4'd6,
      st_mem_wr   = 4'd7,
      st_branch   = 4'd8,
      st_i_exec   = 4'd9,
      st_i_wb     = 4'd10,
      st_jump     = 4'd11,
      st_trap     = 4'd12
   } state_t;

   // ALU operation codes
   localparam logic [3:0] c_alu_add = 4'b0010;
   localparam logic [3:0] c_alu_sub = 4'b0110;
   localparam logic [3:0] c_alu_and = 4'b0000;
   localparam logic [3:0] c_alu_or  = 4'b0001;
   localparam logic [3:0] c_alu_slt = 4'b0111;
   localparam logic [3:0] c_alu_sll = 4'b1000;
   localparam logic [3:0] c_alu_srl = 4'b1001;

   // Opcodes (IR[31:26])
   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_jal   = 6'h03;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_slti  = 6'h0A;
   localparam logic [5:0] c_op_andi  = 6'h0C;
   localparam logic [5:0] c_op_ori   = 6'h0D;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] c_fn_sll = 6'h00;
   localparam logic [5:0] c_fn_srl = 6'h02;
   localparam logic [5:0] c_fn_add = 6'h20;
   localparam logic [5:0] c_fn_sub = 6'h22;
   localparam logic [5:0] c_fn_and = 6'h24;
   localparam logic [5:0] c_fn_or  = 6'h25;
   localparam logic [5:0] c_fn_slt = 6'h2A;

   // Datapath mux selects
   localparam logic       c_iord_pc      = 1'b0;
   localparam logic       c_iord_aluout  = 1'b1;
   localparam logic [1:0] c_rdst_rt      = 2'd0;
   localparam logic [1:0] c_rdst_rd      = 2'd1;
   localparam logic [1:0] c_rdst_r31     = 2'd2;
   localparam logic [1:0] c_m2r_aluout   = 2'd0;
   localparam logic [1:0] c_m2r_mdr      = 2'd1;
   localparam logic [1:0] c_m2r_pc       = 2'd2;
   localparam logic       c_srca_pc      = 1'b0;
   localparam logic       c_srca_areg    = 1'b1;
   localparam logic [1:0] c_srcb_breg    = 2'd0;
   localparam logic [1:0] c_srcb_four    = 2'd1;
   localparam logic [1:0] c_srcb_imm     = 2'd2;
   localparam logic [1:0] c_srcb_imm_sl2 = 2'd3;
   localparam logic [1:0] c_pcsrc_alu    = 2'd0;
   localparam logic [1:0] c_pcsrc_aluout = 2'd1;
   localparam logic [1:0] c_pcsrc_jump   = 2'd2;

   // Logical immediates are zero-extended rather than sign-extended
   function automatic logic needs_zero_ext(input logic [5:0] op);
      return (op == c_op_andi) || (op == c_op_ori);
   endfunction

   // States that stall on the memory handshake and feed the timeout counter
   function automatic logic is_mem_wait(input state_t s);
      return (s == st_fetch) || (s == st_mem_rd) || (s == st_mem_wr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_decode
// Brief    : Combinational opcode/func to ALU operation decode with an
//            illegal-instruction flag. Result is latched by the control FSM
//            during DECODE.
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);

   // Map instruction fields to an ALU operation; unknown encodings flag illegal
   always_comb begin
      alu_ctrl = c_alu_add;
      illegal  = 1'b0;
      case (opcode)
         c_op_rtype: begin
            case (func)
               c_fn_add: alu_ctrl = c_alu_add;
               c_fn_sub: alu_ctrl = c_alu_sub;
               c_fn_and: alu_ctrl = c_alu_and;
               c_fn_or:  alu_ctrl = c_alu_or;
               c_fn_slt: alu_ctrl = c_alu_slt;
               c_fn_sll: alu_ctrl = c_alu_sll;
               c_fn_srl: alu_ctrl = c_alu_srl;
               default:  illegal  = 1'b1;
            endcase
         end
         c_op_lw, c_op_sw, c_op_addi, c_op_j, c_op_jal: alu_ctrl = c_alu_add;
         c_op_beq, c_op_bne: alu_ctrl = c_alu_sub;
         c_op_andi:          alu_ctrl = c_alu_and;
         c_op_ori:           alu_ctrl = c_alu_or;
         c_op_slti:          alu_ctrl = c_alu_slt;
         default:            illegal  = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multicycle MIPS datapath. Sequences
//            fetch/decode/execute/memory/writeback and drives all datapath
//            enables and selects. Memory waits are bounded by MEM_TIMEOUT;
//            illegal instructions and timeouts park the FSM in TRAP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ext_zero,
   output logic [3:0] alu_ctrl,
   output logic [1:0] pc_source,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       trap
);

   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t        r_state;
   state_t        w_next_state;
   logic [TW-1:0] r_tmo;
   logic [31:0]   w_tmo_inc;
   logic          w_tmo_hit;
   logic          r_trap;

   // Instruction attributes captured in DECODE
   logic [3:0]    r_alu_ctrl;
   logic          r_illegal;
   logic          r_is_store;
   logic          r_is_bne;
   logic          r_is_jal;
   logic          r_ext_zero;

   logic [3:0]    w_dec_alu;
   logic          w_dec_illegal;

   // Ungated datapath controls decoded from the state register
   logic          w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
   logic          w_ir_write, w_reg_write, w_alu_src_a, w_ext_zero, w_instr_done;
   logic [1:0]    w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source;
   logic [3:0]    w_alu_ctrl;

   alu_ctrl_decode u_alu_dec (
      .opcode   (opcode),
      .func     (func),
      .alu_ctrl (w_dec_alu),
      .illegal  (w_dec_illegal)
   );

   assign w_tmo_inc = 32'(r_tmo) + 32'd1;
   assign w_tmo_hit = (MEM_TIMEOUT != 0) && (w_tmo_inc == 32'(MEM_TIMEOUT));

   // Next-state selection; a completing handshake wins over an expiring timeout
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         st_fetch: begin
            if (mem_ready)      w_next_state = st_decode;
            else if (w_tmo_hit) w_next_state = st_trap;
         end
         st_decode: begin
            case (opcode)
               c_op_rtype:                                w_next_state = st_r_exec;
               c_op_lw, c_op_sw:                          w_next_state = st_mem_addr;
               c_op_beq, c_op_bne:                        w_next_state = st_branch;
               c_op_addi, c_op_andi, c_op_ori, c_op_slti: w_next_state = st_i_exec;
               c_op_j, c_op_jal:                          w_next_state = st_jump;
               default:                                   w_next_state = st_trap;
            endcase
         end
         st_r_exec:   w_next_state = r_illegal ? st_trap : st_r_wb;
         st_mem_addr: w_next_state = r_is_store ? st_mem_wr : st_mem_rd;
         st_mem_rd: begin
            if (mem_ready)      w_next_state = st_mem_wb;
            else if (w_tmo_hit) w_next_state = st_trap;
         end
         st_mem_wr: begin
            if (mem_ready)      w_next_state = st_fetch;
            else if (w_tmo_hit) w_next_state = st_trap;
         end
         st_i_exec:   w_next_state = st_i_wb;
         st_r_wb, st_mem_wb, st_i_wb, st_branch, st_jump: w_next_state = st_fetch;
         st_trap:     w_next_state = st_trap;
         default:     w_next_state = st_trap;
      endcase
   end

   // State register, sticky trap, wait counter and DECODE-time instruction latch
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= st_fetch;
         r_trap     <= 1'b0;
         r_tmo      <= '0;
         r_alu_ctrl <= c_alu_add;
         r_illegal  <= 1'b0;
         r_is_store <= 1'b0;
         r_is_bne   <= 1'b0;
         r_is_jal   <= 1'b0;
         r_ext_zero <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state == st_trap)
            r_trap <= 1'b1;
         if ((w_next_state == r_state) && is_mem_wait(r_state) && !mem_ready)
            r_tmo <= w_tmo_inc[TW-1:0];
         else
            r_tmo <= '0;
         if (r_state == st_decode) begin
            r_alu_ctrl <= w_dec_alu;
            r_illegal  <= w_dec_illegal;
            r_is_store <= (opcode == c_op_sw);
            r_is_bne   <= (opcode == c_op_bne);
            r_is_jal   <= (opcode == c_op_jal);
            r_ext_zero <= needs_zero_ext(opcode);
         end
      end
   end

   // Moore decode of datapath controls; FETCH/MEM_WR qualify their strobes with mem_ready
   always_comb begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_i_or_d        = c_iord_pc;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_dst       = c_rdst_rt;
      w_mem_to_reg    = c_m2r_aluout;
      w_reg_write     = 1'b0;
      w_alu_src_a     = c_srca_pc;
      w_alu_src_b     = c_srcb_breg;
      w_ext_zero      = 1'b0;
      w_alu_ctrl      = c_alu_add;
      w_pc_source     = c_pcsrc_alu;
      w_instr_done    = 1'b0;
      case (r_state)
         st_fetch: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = c_srcb_four;
            w_ir_write  = mem_ready;
            w_pc_write  = mem_ready;
         end
         st_decode: begin
            w_alu_src_b = c_srcb_imm_sl2;
         end
         st_r_exec: begin
            w_alu_src_a = c_srca_areg;
            w_alu_src_b = c_srcb_breg;
            w_alu_ctrl  = r_alu_ctrl;
         end
         st_r_wb: begin
            w_reg_dst    = c_rdst_rd;
            w_mem_to_reg = c_m2r_aluout;
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         st_mem_addr: begin
            w_alu_src_a = c_srca_areg;
            w_alu_src_b = c_srcb_imm;
         end
         st_mem_rd: begin
            w_mem_read = 1'b1;
            w_i_or_d   = c_iord_aluout;
         end
         st_mem_wb: begin
            w_reg_dst    = c_rdst_rt;
            w_mem_to_reg = c_m2r_mdr;
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         st_mem_wr: begin
            w_mem_write  = 1'b1;
            w_i_or_d     = c_iord_aluout;
            w_instr_done = mem_ready;
         end
         st_branch: begin
            w_alu_src_a     = c_srca_areg;
            w_alu_src_b     = c_srcb_breg;
            w_alu_ctrl      = c_alu_sub;
            w_pc_source     = c_pcsrc_aluout;
            w_pc_write_cond = r_is_bne ? ~zero : zero;
            w_instr_done    = 1'b1;
         end
         st_i_exec: begin
            w_alu_src_a = c_srca_areg;
            w_alu_src_b = c_srcb_imm;
            w_alu_ctrl  = r_alu_ctrl;
            w_ext_zero  = r_ext_zero;
         end
         st_i_wb: begin
            w_reg_dst    = c_rdst_rt;
            w_mem_to_reg = c_m2r_aluout;
            w_reg_write  = 1'b1;
            w_instr_done = 1'b1;
         end
         st_jump: begin
            w_pc_source  = c_pcsrc_jump;
            w_pc_write   = 1'b1;
            w_instr_done = 1'b1;
            if (r_is_jal) begin
               w_reg_dst    = c_rdst_r31;
               w_mem_to_reg = c_m2r_pc;
               w_reg_write  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Reset held low masks every strobe and parks selects at their idle values
   assign pc_write      = rst_n & w_pc_write;
   assign pc_write_cond = rst_n & w_pc_write_cond;
   assign mem_read      = rst_n & w_mem_read;
   assign mem_write     = rst_n & w_mem_write;
   assign ir_write      = rst_n & w_ir_write;
   assign reg_write     = rst_n & w_reg_write;
   assign instr_done    = rst_n & w_instr_done;
   assign i_or_d        = rst_n & w_i_or_d;
   assign alu_src_a     = rst_n & w_alu_src_a;
   assign ext_zero      = rst_n & w_ext_zero;
   assign reg_dst       = rst_n ? w_reg_dst    : 2'd0;
   assign mem_to_reg    = rst_n ? w_mem_to_reg : 2'd0;
   assign alu_src_b     = rst_n ? w_alu_src_b  : 2'd0;
   assign pc_source     = rst_n ? w_pc_source  : 2'd0;
   assign alu_ctrl      = rst_n ? w_alu_ctrl   : c_alu_add;
   assign state         = r_state;
   assign trap          = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed self-checking bench for multicycle_control. Each cycle
//            compares the debug state and a packed vector of all controls
//            against hand-written expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, func;
   logic       zero, mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
   logic       reg_write, alu_src_a, ext_zero, instr_done, trap;
   logic [3:0] alu_ctrl, state;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MEM_TIMEOUT(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .func          (func),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .ext_zero      (ext_zero),
      .alu_ctrl      (alu_ctrl),
      .pc_source     (pc_source),
      .state         (state),
      .instr_done    (instr_done),
      .trap          (trap)
   );

   // Observed controls packed in the same field order as ctl() below
   logic [22:0] w_obs;
   assign w_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   reg_write, instr_done, trap, reg_dst, mem_to_reg, alu_src_a,
                   alu_src_b, ext_zero, pc_source, alu_ctrl};

   function automatic logic [22:0] ctl(input int pcw, pcc, iod, mr, mw, irw, rw, done, trp,
                                       input int rd, m2r, sa, sb, ez, ps, alu);
      ctl = {pcw[0], pcc[0], iod[0], mr[0], mw[0], irw[0], rw[0], done[0], trp[0],
             rd[1:0], m2r[1:0], sa[0], sb[1:0], ez[0], ps[1:0], alu[3:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One cycle: drive inputs just after the falling edge, check mid-low phase
   task automatic cyc(input string tag, input logic rn, input logic mr, input logic z,
                      input int exp_state, input logic [22:0] exp_ctl);
      rst_n     = rn;
      mem_ready = mr;
      zero      = z;
      #1;
      chk({tag, " state"}, 32'(state), 32'(exp_state));
      chk({tag, " ctl"},   32'(w_obs), 32'(exp_ctl));
      @(negedge clk);
   endtask

   logic [22:0] v_idle, v_fetch, v_fwait, v_dec, v_rex_add, v_rex_sll, v_rwb;
   logic [22:0] v_iex_ori, v_iwb, v_madr, v_mrd, v_mwb, v_mwr_rdy, v_mwr_w;
   logic [22:0] v_beq_t, v_bne_nt, v_jal, v_trap;

   initial begin
      //              pcw pcc iod mr mw irw rw dn tr  rd m2r sa sb ez ps alu
      v_idle    = ctl(0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 2);
      v_fetch   = ctl(1,  0,  0,  1, 0, 1,  0, 0, 0,  0, 0,  0, 1, 0, 0, 2);
      v_fwait   = ctl(0,  0,  0,  1, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0, 0, 2);
      v_dec     = ctl(0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 3, 0, 0, 2);
      v_rex_add = ctl(0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0, 0, 2);
      v_rex_sll = ctl(0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0,  1, 0, 0, 0, 8);
      v_rwb     = ctl(0,  0,  0,  0, 0, 0,  1, 1, 0,  1, 0,  0, 0, 0, 0, 2);
      v_iex_ori = ctl(0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0,  1, 2, 1, 0, 1);
      v_iwb     = ctl(0,  0,  0,  0, 0, 0,  1, 1, 0,  0, 0,  0, 0, 0, 0, 2);
      v_madr    = ctl(0,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0,  1, 2, 0, 0, 2);
      v_mrd     = ctl(0,  0,  1,  1, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 2);
      v_mwb     = ctl(0,  0,  0,  0, 0, 0,  1, 1, 0,  0, 1,  0, 0, 0, 0, 2);
      v_mwr_rdy = ctl(0,  0,  1,  0, 1, 0,  0, 1, 0,  0, 0,  0, 0, 0, 0, 2);
      v_mwr_w   = ctl(0,  0,  1,  0, 1, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 2);
      v_beq_t   = ctl(0,  1,  0,  0, 0, 0,  0, 1, 0,  0, 0,  1, 0, 0, 1, 6);
      v_bne_nt  = ctl(0,  0,  0,  0, 0, 0,  0, 1, 0,  0, 0,  1, 0, 0, 1, 6);
      v_jal     = ctl(1,  0,  0,  0, 0, 0,  1, 1, 0,  2, 2,  0, 0, 0, 2, 2);
      v_trap    = ctl(0,  0,  0,  0, 0, 0,  0, 0, 1,  0, 0,  0, 0, 0, 0, 2);

      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00; func = 6'h00;
      @(negedge clk);

      // Reset held: strobes masked even with mem_ready high
      cyc("reset", 0, 1, 0, 0, v_idle);

      // add $3,$1,$2
      opcode = 6'h00; func = 6'h20;
      cyc("add c1", 1, 1, 0, 0, v_fetch);
      cyc("add c2", 1, 1, 0, 1, v_dec);
      cyc("add c3", 1, 1, 0, 2, v_rex_add);
      cyc("add c4", 1, 1, 0, 3, v_rwb);

      // sll: func 0x00 selects shift-left code
      opcode = 6'h00; func = 6'h00;
      cyc("sll c1", 1, 1, 0, 0, v_fetch);
      cyc("sll c2", 1, 1, 0, 1, v_dec);
      cyc("sll c3", 1, 1, 0, 2, v_rex_sll);
      cyc("sll c4", 1, 1, 0, 3, v_rwb);

      // ori: OR with zero-extended immediate
      opcode = 6'h0D; func = 6'h3F;
      cyc("ori c1", 1, 1, 0, 0, v_fetch);
      cyc("ori c2", 1, 1, 0, 1, v_dec);
      cyc("ori c3", 1, 1, 0, 9, v_iex_ori);
      cyc("ori c4", 1, 1, 0, 10, v_iwb);

      // lw with three wait cycles in MEM_RD: 8 cycles total
      opcode = 6'h23; func = 6'h00;
      cyc("lw c1", 1, 1, 0, 0, v_fetch);
      cyc("lw c2", 1, 1, 0, 1, v_dec);
      cyc("lw c3", 1, 1, 0, 4, v_madr);
      cyc("lw c4", 1, 0, 0, 5, v_mrd);
      cyc("lw c5", 1, 0, 0, 5, v_mrd);
      cyc("lw c6", 1, 0, 0, 5, v_mrd);
      cyc("lw c7", 1, 1, 0, 5, v_mrd);
      cyc("lw c8", 1, 1, 0, 6, v_mwb);

      // sw, zero-wait: 4 cycles
      opcode = 6'h2B;
      cyc("sw c1", 1, 1, 0, 0, v_fetch);
      cyc("sw c2", 1, 1, 0, 1, v_dec);
      cyc("sw c3", 1, 1, 0, 4, v_madr);
      cyc("sw c4", 1, 1, 0, 7, v_mwr_rdy);

      // beq taken, then bne not taken, both with zero = 1
      opcode = 6'h04;
      cyc("beq c1", 1, 1, 1, 0, v_fetch);
      cyc("beq c2", 1, 1, 1, 1, v_dec);
      cyc("beq c3", 1, 1, 1, 8, v_beq_t);
      opcode = 6'h05;
      cyc("bne c1", 1, 1, 1, 0, v_fetch);
      cyc("bne c2", 1, 1, 1, 1, v_dec);
      cyc("bne c3", 1, 1, 1, 8, v_bne_nt);

      // jal: link into r31 while jumping
      opcode = 6'h03;
      cyc("jal c1", 1, 1, 0, 0, v_fetch);
      cyc("jal c2", 1, 1, 0, 1, v_dec);
      cyc("jal c3", 1, 1, 0, 11, v_jal);

      // Illegal opcode parks in TRAP with no strobes
      opcode = 6'h3F;
      cyc("ill c1", 1, 1, 0, 0, v_fetch);
      cyc("ill c2", 1, 1, 0, 1, v_dec);
      for (int i = 0; i < 20; i++) cyc("trap hold", 1, 1, 0, 12, v_trap);
      cyc("trap rst", 0, 0, 0, 12, v_trap);

      // Timeout: 16 wait cycles in FETCH, then TRAP
      for (int i = 0; i < 16; i++) cyc("tmo wait", 1, 0, 0, 0, v_fwait);
      cyc("tmo trap", 1, 0, 0, 12, v_trap);
      cyc("tmo rst", 0, 0, 0, 12, v_trap);

      // mem_ready on the expiring cycle completes the fetch; then sw interrupted by reset
      opcode = 6'h2B;
      for (int i = 0; i < 15; i++) cyc("edge wait", 1, 0, 0, 0, v_fwait);
      cyc("edge rdy", 1, 1, 0, 0, v_fetch);
      cyc("edge dec", 1, 1, 0, 1, v_dec);
      cyc("swr c3", 1, 1, 0, 4, v_madr);
      cyc("swr c4", 1, 0, 0, 7, v_mwr_w);
      cyc("swr rst", 0, 0, 0, 7, v_idle);
      cyc("swr after", 1, 1, 0, 0, v_fetch);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
